// File: rtl/adder.sv
// Registered WIDTH-bit adder with a single-entry valid/ready output stage.
// Define ADDER_SATURATE_EN to clamp OUT to all-ones on overflow instead of wrapping.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] result;
  logic             in_xfer;
  logic             out_xfer;

  assign full_sum = {1'b0, A} + {1'b0, B};

`ifdef ADDER_SATURATE_EN
  assign result = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
  assign result = full_sum[WIDTH-1:0];
`endif

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // live_q keeps in_ready low until the first edge after reset release,
  // so nothing can be accepted on the release edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      live_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_xfer) begin
      sum_d   = result;
      carry_d = full_sum[WIDTH];
    end
    case (state_q)
      EMPTY:   if (in_xfer) state_d = FULL;
      FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = live_q & ((state_q == EMPTY) | out_ready);
    OUT       = sum_q;
    carry     = carry_q;
  end

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for adder (WIDTH=32); honours ADDER_SATURATE_EN
// when choosing expected overflow results.
module tb_adder;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A, B;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] OUT;
  logic             carry, out_valid, out_ready;

  int checks = 0;
  int failures = 0;

  adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
    .OUT(OUT), .carry(carry), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_wrap, exp_big;

  initial begin
`ifdef ADDER_SATURATE_EN
    exp_wrap = 32'hFFFF_FFFF;
    exp_big  = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h0000_0001;
    exp_big  = 32'h0000_0000;
`endif
    rst = 1'b0; A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    step(); step();
    rst = 1'b1;
    check("release_in_ready", in_ready, 0);
    step();
    check("post_release_in_ready", in_ready, 1);

    // Basic 5+7
    A = 5; B = 7; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_out", OUT, 12);
    check("basic_carry", carry, 0);
    check("basic_valid", out_valid, 1);
    step();
    check("basic_consumed", out_valid, 0);
    check("basic_hold", OUT, 12);

    // Wrap / saturate
    A = 32'hFFFF_FFFF; B = 32'h0000_0002; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("wrap_out", OUT, exp_wrap);
    check("wrap_carry", carry, 1);
    step();

    // Backpressure: hold 12 for 5 cycles while offering a new pair
    A = 5; B = 7; in_valid = 1'b1; out_ready = 1'b0;
    step();
    A = 100; B = 200;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out", OUT, 12);
      check("bp_valid", out_valid, 1);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    step();
    check("bp_consumed", out_valid, 0);
    check("bp_out_unchanged", OUT, 12);

    // Throughput: one result per cycle
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      A = WIDTH'(i); B = WIDTH'(i);
      step();
      check("tp_out", OUT, 64'(2 * i));
      check("tp_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check("tp_drain", out_valid, 0);

    // Boundaries
    A = 0; B = 0; in_valid = 1'b1;
    step();
    check("zero_out", OUT, 0);
    check("zero_carry", carry, 0);
    A = 32'h8000_0000; B = 32'h8000_0000;
    step();
    in_valid = 1'b0;
    check("msb_out", OUT, exp_big);
    check("msb_carry", carry, 1);
    step();

    // Reset while FULL
    A = 5; B = 7; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_out", OUT, 0);
    check("async_rst_carry", carry, 0);
    check("async_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b1; A = 9; B = 9; in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("release_edge_no_xfer", out_valid, 0);
    check("release_edge_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("after_release_out", OUT, 18);
    check("after_release_valid", out_valid, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
